distance_pair_scheduler: RTL and testbench

// - Sequences a DistanceCalculator instance over every index pair (idx1<idx2) of one fw x fw filter window.
// - Emits one {idx1, idx2, dr, dr_valid} record per pair on a valid/ready stream to the redundancy table.
// - Sits between the layer-config registers and the redundancy matcher; one window config per start pulse.

---
 rtl/distance_pair_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_distance_pair_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/distance_pair_scheduler.sv
// distance_pair_scheduler
//   Walks every index pair (idx1 < idx2) of one fw x fw filter window. For each
//   pair it emits {idx1, idx2, dr, dr_ok} on a valid/ready stream for the
//   redundancy table. One window configuration is processed per start pulse.
//
//   Ports
//     clk, reset           rising-edge clock, async active-high reset
//     start                1-cycle pulse, honoured only while idle; samples cfg_*
//     cfg_ow/cfg_fw/cfg_st output feature width, filter width, stride
//     busy                 high while records are being generated or drained
//     done                 1-cycle pulse after the last record is accepted
//     err                  1-cycle pulse on an illegal config (no records emitted)
//     out_valid/out_ready  record handshake
//     out_idx1/out_idx2    pair indices
//     out_dr/out_dr_ok     distance result and its validity
//     pair_cnt             records accepted since start
//
//   Build option: DIST_SKIP_INVALID_EN -- pairs with an invalid distance are
//   not emitted. The generator still spends one cycle on each skipped pair.

module distance_calculator #(
  parameter int WORD_WIDTH = 8,
  parameter int DIST_WIDTH = 7
) (
  input  logic [WORD_WIDTH-1:0] ow,
  input  logic [WORD_WIDTH-1:0] fw,
  input  logic [WORD_WIDTH-1:0] st,
  input  logic [WORD_WIDTH-1:0] idx1,
  input  logic [WORD_WIDTH-1:0] idx2,
  output logic [DIST_WIDTH-1:0] dr,
  output logic                  valid
);
  localparam int NW = 2 * WORD_WIDTH;
  localparam int FW = NW + 2;

  logic [WORD_WIDTH-1:0] fw_s, st_s, r1, c1, r2, c2, drow, qrow;
  logic signed [WORD_WIDTH:0] dcol, st_sg, qcol;
  logic [NW-1:0] prod;
  logic [FW-1:0] full;
  logic row_ok, col_ok, fits;

  always_comb begin
    // A zero divisor only occurs on configs that are rejected before use.
    fw_s  = (fw == '0) ? WORD_WIDTH'(1) : fw;
    st_s  = (st == '0) ? WORD_WIDTH'(1) : st;
    r1    = idx1 / fw_s;
    c1    = idx1 % fw_s;
    r2    = idx2 / fw_s;
    c2    = idx2 % fw_s;
    drow  = r2 - r1;
    dcol  = $signed({1'b0, c2}) - $signed({1'b0, c1});
    st_sg = $signed({1'b0, st_s});
    row_ok = (drow % st_s) == '0;
    col_ok = (dcol % st_sg) == '0;
    qrow  = drow / st_s;
    qcol  = dcol / st_sg;
    prod  = {{WORD_WIDTH{1'b0}}, qrow} * {{WORD_WIDTH{1'b0}}, ow};
    // Offset in output space: whole rows times ow plus signed column step.
    full  = {2'b00, prod} + {{(FW-WORD_WIDTH-1){qcol[WORD_WIDTH]}}, qcol};
    fits  = !full[FW-1] && (full[FW-2:DIST_WIDTH] == '0);
    valid = row_ok && col_ok && fits;
    dr    = full[DIST_WIDTH-1:0];
  end
endmodule

module distance_pair_scheduler #(
  parameter int WORD_WIDTH = 8,
  parameter int DIST_WIDTH = 7,
  parameter int MAX_C_SIZE = 128,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_ow,
  input  logic [WORD_WIDTH-1:0] cfg_fw,
  input  logic [WORD_WIDTH-1:0] cfg_st,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_idx1,
  output logic [WORD_WIDTH-1:0] out_idx2,
  output logic [DIST_WIDTH-1:0] out_dr,
  output logic                  out_dr_ok,
  output logic [CNT_WIDTH-1:0]  pair_cnt
);
  localparam int NW = 2 * WORD_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [WORD_WIDTH-1:0] ow_q, fw_q, st_q, g1, g2;
  logic [NW-1:0]         n_elems;
  logic [DIST_WIDTH-1:0] dc_dr;
  logic dc_valid, bad, last_col, last_pair, advance, load, accept;

  distance_calculator #(
    .WORD_WIDTH(WORD_WIDTH),
    .DIST_WIDTH(DIST_WIDTH)
  ) u_dc (
    .ow(ow_q), .fw(fw_q), .st(st_q),
    .idx1(g1), .idx2(g2),
    .dr(dc_dr), .valid(dc_valid)
  );

  always_comb begin
    n_elems   = {{WORD_WIDTH{1'b0}}, fw_q} * {{WORD_WIDTH{1'b0}}, fw_q};
    bad       = (fw_q == '0) || (st_q == '0) ||
                (n_elems > NW'(MAX_C_SIZE)) || (n_elems < NW'(2));
    last_col  = {{WORD_WIDTH{1'b0}}, g2} == (n_elems - NW'(1));
    last_pair = last_col && ({{WORD_WIDTH{1'b0}}, g1} == (n_elems - NW'(2)));
    accept    = out_valid && out_ready;
    advance   = (state == S_RUN) && (!out_valid || out_ready);
`ifdef DIST_SKIP_INVALID_EN
    load      = advance && dc_valid;
`else
    load      = advance;
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: state_nx = bad ? S_IDLE : S_RUN;
      S_RUN:   if (advance && last_pair) state_nx = S_DRAIN;
      // Also covers the case where nothing is pending (all pairs skipped).
      S_DRAIN: if (!out_valid || out_ready) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ow_q      <= '0;
      fw_q      <= '0;
      st_q      <= '0;
      g1        <= '0;
      g2        <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_idx1  <= '0;
      out_idx2  <= '0;
      out_dr    <= '0;
      out_dr_ok <= 1'b0;
      pair_cnt  <= '0;
    end else begin
      state <= state_nx;
      err   <= (state == S_CHECK) && bad;

      if (state == S_IDLE && start) begin
        ow_q     <= cfg_ow;
        fw_q     <= cfg_fw;
        st_q     <= cfg_st;
        g1       <= '0;
        g2       <= WORD_WIDTH'(1);
        pair_cnt <= '0;
      end else if (accept) begin
        pair_cnt <= pair_cnt + CNT_WIDTH'(1);
      end

      if (advance) begin
        if (last_col) begin
          g1 <= g1 + WORD_WIDTH'(1);
          g2 <= g1 + WORD_WIDTH'(2);
        end else begin
          g2 <= g2 + WORD_WIDTH'(1);
        end
      end

      if (load) begin
        out_valid <= 1'b1;
        out_idx1  <= g1;
        out_idx2  <= g2;
        out_dr    <= dc_dr;
        out_dr_ok <= dc_valid;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_distance_pair_scheduler.sv
module tb_distance_pair_scheduler;
  logic       clk = 1'b0;
  logic       reset, start, out_ready;
  logic [7:0] cfg_ow, cfg_fw, cfg_st;
  logic       busy, done, err, out_valid, out_dr_ok;
  logic [7:0] out_idx1, out_idx2;
  logic [6:0] out_dr;
  logic [13:0] pair_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] lfsr = 16'hACE1;

  distance_pair_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_ow(cfg_ow), .cfg_fw(cfg_fw), .cfg_st(cfg_st),
    .busy(busy), .done(done), .err(err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx1(out_idx1), .out_idx2(out_idx2),
    .out_dr(out_dr), .out_dr_ok(out_dr_ok), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ow, fw, st;
    int exp_err;
    int exp_cnt, last1, last2;
    int p1, p2, pdr, pok;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent integer model of the distance between two window elements.
  function automatic void dist_model(input int ow, input int fw, input int st,
                                     input int i1, input int i2,
                                     output int dr, output int ok);
    int dy, dx, d;
    dy = i2 / fw - i1 / fw;
    dx = i2 % fw - i1 % fw;
    d  = (dy / st) * ow + dx / st;
    ok = ((dy % st) == 0 && (dx % st) == 0 && d >= 0 && d < 128) ? 1 : 0;
    dr = d & 127;
  endfunction

  task automatic run_seq(input vec_t v, input bit use_lfsr, input bit inject);
    int e1, e2, n, recv, cycles, last_acc, mdr, mok;
    bit finished, prev_stall, injected, probe_seen;
    logic [7:0] h1, h2;
    logic [6:0] hdr;
    logic       hok;
    e1 = 0; e2 = 1; n = v.fw * v.fw; recv = 0; cycles = 0; last_acc = -10;
    finished = 0; prev_stall = 0; injected = 0; probe_seen = 0;
    h1 = '0; h2 = '0; hdr = '0; hok = 1'b0;

    @(negedge clk);
    cfg_ow = 8'(v.ow); cfg_fw = 8'(v.fw); cfg_st = 8'(v.st);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_ow = 8'd7; cfg_fw = 8'd2; cfg_st = 8'd1;   // must not be re-sampled
    check("check_busy", int'(busy), 0);
    check("check_valid", int'(out_valid), 0);
    @(negedge clk);
    if (v.exp_err != 0) begin
      check("err_pulse", int'(err), 1);
      check("err_busy", int'(busy), 0);
      check("err_valid", int'(out_valid), 0);
      @(negedge clk);
      check("err_width", int'(err), 0);
      check("err_valid2", int'(out_valid), 0);
      check("err_busy2", int'(busy), 0);
      return;
    end
    check("no_err", int'(err), 0);
    check("run_busy", int'(busy), 1);
    check("run_valid_early", int'(out_valid), 0);
    @(negedge clk);
    check("first_latency", int'(out_valid), 1);

    while (!finished && cycles < 20000) begin
      if (done) begin
        check("done_timing", cycles, last_acc + 1);
        check("final_cnt", int'(pair_cnt), v.exp_cnt);
        check("recv_cnt", recv, v.exp_cnt);
        finished = 1;
      end else begin
        if (prev_stall) begin
          check("stall_hold", int'({out_valid, out_idx1, out_idx2, out_dr, out_dr_ok}),
                int'({1'b1, h1, h2, hdr, hok}));
        end
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        out_ready = use_lfsr ? lfsr[0] : 1'b1;
        if (out_valid && out_ready) begin
          if (recv >= v.exp_cnt) begin
            check("extra_record", recv, v.exp_cnt - 1);
          end else begin
            dist_model(v.ow, v.fw, v.st, e1, e2, mdr, mok);
            check("pair_cnt_run", int'(pair_cnt), recv);
            check("idx1", int'(out_idx1), e1);
            check("idx2", int'(out_idx2), e2);
            check("dr", int'(out_dr), mdr);
            check("dr_ok", int'(out_dr_ok), mok);
            if (e1 == v.p1 && e2 == v.p2) begin
              probe_seen = 1;
              check("probe_dr", int'(out_dr), v.pdr);
              check("probe_ok", int'(out_dr_ok), v.pok);
            end
            if (recv == v.exp_cnt - 1) begin
              check("last_idx1", int'(out_idx1), v.last1);
              check("last_idx2", int'(out_idx2), v.last2);
            end
            if (e2 == n - 1) begin e1++; e2 = e1 + 1; end
            else e2++;
          end
          recv++;
          last_acc = cycles;
        end
        prev_stall = out_valid && !out_ready;
        h1 = out_idx1; h2 = out_idx2; hdr = out_dr; hok = out_dr_ok;
        if (inject && recv == 5 && !injected) begin
          cfg_ow = 8'd42; cfg_fw = 8'd5; cfg_st = 8'd2;
          start = 1'b1;
          injected = 1;
        end else begin
          start = 1'b0;
        end
        cycles++;
        @(negedge clk);
      end
    end
    if (!finished) check("timeout", 0, 1);
    check("probe_seen", int'(probe_seen), 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("done_width", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_cnt_hold", int'(pair_cnt), v.exp_cnt);
  endtask

  initial begin
    //          ow  fw st err cnt  last1 last2 p1 p2  pdr pok
    vecs[0] = '{20,  3, 1, 0,   36,   7,   8,  0,  4, 21, 1};
    vecs[1] = '{42,  5, 2, 0,  300,  23,  24,  0, 12, 43, 1};
    vecs[2] = '{20,  2, 1, 0,    6,   2,   3,  1,  2, 19, 1};
    vecs[3] = '{ 5, 11, 1, 0, 7260, 119, 120,  0,120, 60, 1};
    vecs[4] = '{20,  3, 2, 0,   36,   7,   8,  0,  1,  0, 0};
    vecs[5] = '{100, 3, 1, 0,   36,   7,   8,  0,  6, 72, 0};
    vecs[6] = '{20, 12, 1, 1,    0,   0,   0,  0,  0,  0, 0};
    vecs[7] = '{20,  3, 0, 1,    0,   0,   0,  0,  0,  0, 0};
    vecs[8] = '{20,  1, 1, 1,    0,   0,   0,  0,  0,  0, 0};
    vecs[9] = '{20,  0, 1, 1,    0,   0,   0,  0,  0,  0, 0};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    cfg_ow = '0; cfg_fw = '0; cfg_st = '0;
    repeat (3) @(negedge clk);
    check("rst_state", int'({busy, done, err, out_valid, out_dr_ok}), 0);
    check("rst_regs", int'({out_idx1, out_idx2, out_dr}), 0);
    check("rst_cnt", int'(pair_cnt), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_seq(vecs[i], 1'b0, 1'b0);

    // Random backpressure on the 300-pair window.
    run_seq(vecs[1], 1'b1, 1'b0);

    // A start during RUN with another config must be ignored.
    run_seq(vecs[0], 1'b0, 1'b1);

    // Reset in the middle of a run.
    begin
      bit saw_done;
      saw_done = 0;
      @(negedge clk);
      cfg_ow = 8'd20; cfg_fw = 8'd3; cfg_st = 8'd1; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre_reset_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_cnt", int'(pair_cnt), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        if (done || out_valid || busy) saw_done = 1;
      end
      check("post_rst_quiet", int'(saw_done), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
